multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM that sequences the instruction fetch/decode datapath (PC, IR, regfile, ALU, data memory).
//  Consumes the decoded op/func fields and the ALU zero flag. Emits per-cycle write strobes and mux selects.
//  Supports MIPS subset R-type, addi/andi/ori/xori, lw, sw, beq, bne and j.
//  Traps on illegal opcodes and on data-memory timeouts.
// PARAMETERS
//  CNT_W     32  width of retired-instruction counter
//  WAIT_MAX  8   max MEM-state cycles waiting for dmem_ack before timeout trap (>=1)
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      asynchronous, active-low reset
//  op             in   6      opcode field of current IR
//  func           in   6      function field of current IR
//  zero           in   1      ALU zero flag, valid in EX
//  dmem_ack       in   1      data memory done; sampled in MEM
//  state          out  3      FSM state: IF=0 ID=1 EX=2 MEM=3 WB=4 TRAP=7
//  pc_we          out  1      PC write enable
//  pc_src         out  2      00 PC+4, 01 branch target, 10 jump target
//  ir_we          out  1      instruction register load
//  alu_op         out  3      000 add, 001 sub, 010 and, 011 or, 100 xor, 111 decode func
//  alu_src_b      out  1      0 rt register, 1 extended imm
//  ext_sign       out  1      1 sign-extend imm, 0 zero-extend
//  dmem_req       out  1      data memory request
//  dmem_we        out  1      data memory write (with dmem_req)
//  rf_we          out  1      register file write enable
//  reg_dst        out  1      0 rt, 1 rd
//  mem_to_reg     out  1      0 ALU result, 1 memory data
//  inst_retired   out  CNT_W  count of completed instructions
//  err            out  1      sticky trap flag
//  err_code       out  2      01 illegal opcode, 10 memory timeout, 00 none
// BEHAVIOUR
//  Reset (rst=0, async): state=IF, inst_retired=0, err=0, err_code=00.
//   All strobes (pc_we, ir_we, rf_we, dmem_req, dmem_we) are forced 0 while rst=0.
//   Selects reset to 0.
//  Strobes and selects are combinational from state, plus op/zero/dmem_ack. Any strobe not listed below is 0.
//  IF: ir_we=1, pc_we=1, pc_src=00 -> ID.
//  ID: j (000010): pc_we=1, pc_src=10, retire -> IF.
//   Legal op -> EX. Illegal op -> TRAP, err_code=01.
//  EX, per op:
//   R-type (000000): alu_op=111 -> WB.
//   addi (001000): alu_op=000, alu_src_b=1, ext_sign=1 -> WB.
//   andi/ori/xori: alu_op=010/011/100, alu_src_b=1, ext_sign=0 -> WB.
//   lw/sw (100011/101011): alu_op=000, alu_src_b=1, ext_sign=1 -> MEM.
//   beq/bne (000100/000101): alu_op=001.
//    Taken when (beq & zero) | (bne & ~zero): pc_we=1, pc_src=01 in the same cycle.
//    Retire -> IF, taken or not.
//  MEM: dmem_req=1, dmem_we=(op==sw). A wait counter clears on MEM entry and counts MEM cycles.
//   dmem_ack=1: lw -> WB; sw retires -> IF.
//   No ack in WAIT_MAX consecutive MEM cycles -> TRAP, err_code=10, dmem_req drops.
//   An ack in the WAIT_MAX-th cycle wins over the timeout.
//  WB: rf_we=1, reg_dst=(op==000000), mem_to_reg=(op==lw). Retire -> IF.
//  TRAP: all strobes 0, err=1, held until reset. err_code is captured on TRAP entry.
//  Undefined state encodings (5, 6): go to IF next cycle, all strobes 0.
//  inst_retired: +1 on each retire transition; wraps 2^CNT_W-1 -> 0.
//  Cycles per instruction: j=2, beq/bne=3, ALU=4, sw=4+waits, lw=5+waits (waits = ack delay in cycles).
//  rst asserted mid-instruction: FSM aborts immediately. The partial instruction is not counted.
// TESTING
//  1 Reset: assert rst=0 during MEM of a lw -> state=0, dmem_req=0, inst_retired=0 at once.
//    Release rst -> ir_we=1 on first edge.
//  2 R-type add (op=0, func=100000) -> states 0,1,2,4. rf_we=1 and reg_dst=1 only in cycle 4.
//    inst_retired 0->1.
//  3 lw with dmem_ack delayed 2 cycles -> MEM held 3 cycles, then WB with mem_to_reg=1.
//    7 cycles total.
//  4 beq zero=1 -> pc_we=1, pc_src=01 in EX. beq zero=0 -> pc_we=0 in EX.
//    bne mirrors both. Each takes 3 cycles.
//  5 Illegal op=111111 -> TRAP after ID, err=1, err_code=01.
//    pc_we/ir_we stay 0 for 20 cycles until reset.
//  6 sw with WAIT_MAX=4, no ack -> TRAP after 4th MEM cycle, err_code=10.
//    With ack on 4th cycle instead -> IF, inst_retired+1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for a MIPS-subset fetch/decode/execute datapath.
// Sequences IF/ID/EX/MEM/WB, counts retired instructions and traps on illegal ops or memory timeouts.
module multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             dmem_ack,
  output logic [2:0]       state,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic [2:0]       alu_op,
  output logic             alu_src_b,
  output logic             ext_sign,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [CNT_W-1:0] inst_retired,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_FUNC = 3'b111;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              retire;
  logic              op_legal;
  logic              branch_taken;
  logic              func_unused;

  // The function field is decoded by the ALU control when alu_op selects it.
  assign func_unused = ^func;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
      OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  end

  assign branch_taken = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    retire     = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_PLUS4;
    ir_we      = 1'b0;
    alu_op     = ALU_ADD;
    alu_src_b  = 1'b0;
    ext_sign   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;

    case (state_q)
      S_IF: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        pc_src  = PC_PLUS4;
        state_d = S_ID;
      end

      S_ID: begin
        if (op == OP_J) begin
          pc_we   = 1'b1;
          pc_src  = PC_JUMP;
          retire  = 1'b1;
          state_d = S_IF;
        end else if (op_legal) begin
          state_d = S_EX;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_ILLEGAL;
          state_d    = S_TRAP;
        end
      end

      S_EX: begin
        case (op)
          OP_RTYPE: begin
            alu_op  = ALU_FUNC;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            ext_sign  = 1'b1;
            state_d   = S_WB;
          end
          OP_ANDI: begin
            alu_op    = ALU_AND;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          OP_ORI: begin
            alu_op    = ALU_OR;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          OP_XORI: begin
            alu_op    = ALU_XOR;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            ext_sign  = 1'b1;
            wait_d    = '0;
            state_d   = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            // Branch resolves here, so the PC update shares the compare cycle.
            alu_op = ALU_SUB;
            if (branch_taken) begin
              pc_we  = 1'b1;
              pc_src = PC_BRANCH;
            end
            retire  = 1'b1;
            state_d = S_IF;
          end
          default: begin
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL;
            state_d    = S_TRAP;
          end
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_SW);
        // A late ack on the final allowed cycle still completes the access.
        if (dmem_ack) begin
          if (op == OP_LW) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_IF;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        rf_we      = 1'b1;
        reg_dst    = (op == OP_RTYPE);
        mem_to_reg = (op == OP_LW);
        retire     = 1'b1;
        state_d    = S_IF;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_IF;
      end
    endcase

    // Nothing may strobe the datapath while reset is held.
    if (!rst) begin
      pc_we      = 1'b0;
      pc_src     = PC_PLUS4;
      ir_we      = 1'b0;
      alu_op     = ALU_ADD;
      alu_src_b  = 1'b0;
      ext_sign   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  assign cnt_d = cnt_q + CNT_W'(retire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IF;
      wait_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign state        = state_q;
  assign inst_retired = cnt_q;
  assign err          = err_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with WAIT_MAX=4.
// Walks reset, R-type, lw with delayed ack, branches, j, immediates, sw timeout/late ack and illegal op.
module tb_multicycle_ctrl;

  localparam int CNT_W    = 32;
  localparam int WAIT_MAX = 4;

  logic             clk;
  logic             rst;
  logic [5:0]       op;
  logic [5:0]       func;
  logic             zero;
  logic             dmem_ack;
  logic [2:0]       state;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             ir_we;
  logic [2:0]       alu_op;
  logic             alu_src_b;
  logic             ext_sign;
  logic             dmem_req;
  logic             dmem_we;
  logic             rf_we;
  logic             reg_dst;
  logic             mem_to_reg;
  logic [CNT_W-1:0] inst_retired;
  logic             err;
  logic [1:0]       err_code;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .dmem_ack(dmem_ack),
    .state(state), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .ext_sign(ext_sign), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .inst_retired(inst_retired), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op_v, input logic zero_v, input logic ack_v);
    op       = op_v;
    zero     = zero_v;
    dmem_ack = ack_v;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; op = 6'd0; func = 6'b100000; zero = 1'b0; dmem_ack = 1'b0;
    #1;
    checkOutput("rst_state", state, 0);
    checkOutput("rst_ir_we", ir_we, 0);
    checkOutput("rst_pc_we", pc_we, 0);
    checkOutput("rst_inst", inst_retired, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_err_code", err_code, 0);
    #11;
    rst = 1'b1;
    #1;
    checkOutput("rel_ir_we", ir_we, 1);
    checkOutput("rel_pc_we", pc_we, 1);

    // R-type add
    applyStimulus(6'b000000, 1'b0, 1'b0);
    tick(); checkOutput("r_id_state", state, 1); checkOutput("r_id_rf_we", rf_we, 0);
    tick(); checkOutput("r_ex_state", state, 2); checkOutput("r_ex_alu_op", alu_op, 7);
    checkOutput("r_ex_rf_we", rf_we, 0);
    tick(); checkOutput("r_wb_state", state, 4); checkOutput("r_wb_rf_we", rf_we, 1);
    checkOutput("r_wb_reg_dst", reg_dst, 1); checkOutput("r_wb_inst", inst_retired, 0);
    tick(); checkOutput("r_if_state", state, 0); checkOutput("r_inst", inst_retired, 1);
    checkOutput("r_if_reg_dst", reg_dst, 0);

    // lw with ack arriving in the third MEM cycle
    applyStimulus(6'b100011, 1'b0, 1'b0);
    tick(); checkOutput("lw_id_state", state, 1);
    tick(); checkOutput("lw_ex_state", state, 2); checkOutput("lw_ex_src_b", alu_src_b, 1);
    checkOutput("lw_ex_ext", ext_sign, 1); checkOutput("lw_ex_alu_op", alu_op, 0);
    tick(); checkOutput("lw_m1_state", state, 3); checkOutput("lw_m1_req", dmem_req, 1);
    checkOutput("lw_m1_we", dmem_we, 0);
    tick(); checkOutput("lw_m2_state", state, 3);
    tick(); applyStimulus(6'b100011, 1'b0, 1'b1); checkOutput("lw_m3_state", state, 3);
    tick(); applyStimulus(6'b100011, 1'b0, 1'b0);
    checkOutput("lw_wb_state", state, 4); checkOutput("lw_wb_m2r", mem_to_reg, 1);
    checkOutput("lw_wb_rf_we", rf_we, 1); checkOutput("lw_wb_reg_dst", reg_dst, 0);
    tick(); checkOutput("lw_if_state", state, 0); checkOutput("lw_inst", inst_retired, 2);

    // reset in the middle of a lw MEM phase
    tick(); tick(); tick();
    checkOutput("ab_mem_state", state, 3);
    rst = 1'b0;
    #1;
    checkOutput("ab_state", state, 0); checkOutput("ab_req", dmem_req, 0);
    checkOutput("ab_inst", inst_retired, 0); checkOutput("ab_ir_we", ir_we, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ab_rel_ir_we", ir_we, 1);

    // beq/bne taken and not taken
    applyStimulus(6'b000100, 1'b1, 1'b0);
    tick(); tick(); checkOutput("beq1_pc_we", pc_we, 1); checkOutput("beq1_pc_src", pc_src, 1);
    checkOutput("beq1_alu_op", alu_op, 1);
    tick(); checkOutput("beq1_state", state, 0); checkOutput("beq1_inst", inst_retired, 1);
    applyStimulus(6'b000100, 1'b0, 1'b0);
    tick(); tick(); checkOutput("beq0_pc_we", pc_we, 0);
    tick(); checkOutput("beq0_inst", inst_retired, 2);
    applyStimulus(6'b000101, 1'b0, 1'b0);
    tick(); tick(); checkOutput("bne0_pc_we", pc_we, 1); checkOutput("bne0_pc_src", pc_src, 1);
    tick(); checkOutput("bne0_inst", inst_retired, 3);
    applyStimulus(6'b000101, 1'b1, 1'b0);
    tick(); tick(); checkOutput("bne1_pc_we", pc_we, 0);
    tick(); checkOutput("bne1_state", state, 0); checkOutput("bne1_inst", inst_retired, 4);

    // jump
    applyStimulus(6'b000010, 1'b0, 1'b0);
    tick(); checkOutput("j_pc_we", pc_we, 1); checkOutput("j_pc_src", pc_src, 2);
    tick(); checkOutput("j_state", state, 0); checkOutput("j_inst", inst_retired, 5);

    // immediates
    applyStimulus(6'b001000, 1'b0, 1'b0);
    tick(); tick(); checkOutput("addi_alu_op", alu_op, 0); checkOutput("addi_ext", ext_sign, 1);
    checkOutput("addi_src_b", alu_src_b, 1);
    tick(); checkOutput("addi_reg_dst", reg_dst, 0); checkOutput("addi_rf_we", rf_we, 1);
    tick(); checkOutput("addi_inst", inst_retired, 6);
    applyStimulus(6'b001101, 1'b0, 1'b0);
    tick(); tick(); checkOutput("ori_alu_op", alu_op, 3); checkOutput("ori_ext", ext_sign, 0);
    tick(); tick(); checkOutput("ori_inst", inst_retired, 7);

    // sw with ack on the last allowed MEM cycle
    applyStimulus(6'b101011, 1'b0, 1'b0);
    tick(); tick();
    tick(); checkOutput("sw_m1_we", dmem_we, 1); checkOutput("sw_m1_req", dmem_req, 1);
    tick(); tick();
    tick(); applyStimulus(6'b101011, 1'b0, 1'b1); checkOutput("sw_m4_state", state, 3);
    tick(); applyStimulus(6'b101011, 1'b0, 1'b0);
    checkOutput("sw_ack_state", state, 0); checkOutput("sw_ack_inst", inst_retired, 8);
    checkOutput("sw_ack_err", err, 0);

    // sw timeout
    tick(); tick();
    tick(); tick(); tick();
    tick(); checkOutput("swto_m4_state", state, 3);
    tick(); checkOutput("swto_state", state, 7); checkOutput("swto_err", err, 1);
    checkOutput("swto_code", err_code, 2); checkOutput("swto_req", dmem_req, 0);
    checkOutput("swto_inst", inst_retired, 8);

    rst = 1'b0;
    #1;
    checkOutput("rst2_err", err, 0); checkOutput("rst2_code", err_code, 0);
    #2;
    rst = 1'b1;

    // illegal opcode
    applyStimulus(6'b111111, 1'b0, 1'b0);
    tick(); checkOutput("ill_id_state", state, 1);
    tick(); checkOutput("ill_state", state, 7); checkOutput("ill_err", err, 1);
    checkOutput("ill_code", err_code, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("ill_hold_pc_we", pc_we, 0);
      checkOutput("ill_hold_ir_we", ir_we, 0);
    end
    checkOutput("ill_hold_state", state, 7);
    rst = 1'b0;
    #1;
    checkOutput("rst3_state", state, 0); checkOutput("rst3_err", err, 0);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
